// File: rtl/grab_trigger_ctrl_pkg.sv
// Shared encodings and default widths for the grab trigger controller.
package grab_trigger_ctrl_pkg;

    localparam int unsigned DEF_NUM_HW_TRIG = 4;
    localparam int unsigned DEF_FILT_W      = 8;
    localparam int unsigned DEF_DLY_W       = 24;
    localparam int unsigned DEF_CNT_W       = 16;
    localparam int unsigned SRC_W           = 3;
    localparam int unsigned ACT_W           = 3;

    typedef enum logic [SRC_W-1:0] {
        SRC_IMMEDIATE = 3'd1,
        SRC_HW_TRIG   = 3'd2,
        SRC_SW_TRIG   = 3'd3,
        SRC_SFNC      = 3'd4
    } trig_src_t;

    typedef enum logic [ACT_W-1:0] {
        ACT_RISING   = 3'd0,
        ACT_FALLING  = 3'd1,
        ACT_ANY      = 3'd2,
        ACT_LEVEL_HI = 3'd3,
        ACT_LEVEL_LO = 3'd4
    } trig_act_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DELAY = 2'd1,
        ST_REQ   = 2'd2
    } grab_state_t;

    // Source and activation captured when the FSM leaves IDLE.
    typedef struct packed {
        logic [SRC_W-1:0] src;
        logic [ACT_W-1:0] act;
    } trig_cfg_t;

    // Edge activations can be missed or queued; level activations cannot.
    function automatic logic is_edge_act(input logic [ACT_W-1:0] act);
        return (act != ACT_LEVEL_HI) && (act != ACT_LEVEL_LO);
    endfunction

endpackage

// File: rtl/grab_trig_filter.sv
// Two-flop synchroniser and debounce filter for one hardware trigger line.
module grab_trig_filter
    import grab_trigger_ctrl_pkg::*;
#(
    parameter int unsigned FILT_W = DEF_FILT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              din,
    input  logic [FILT_W-1:0] filt_len,
    output logic              deb_c
);

    logic              sync1;
    logic              sync2;
    logic              deb;
    logic [FILT_W-1:0] cnt;

    // A zero length bypasses the filter so the synced line is seen directly.
    assign deb_c = (filt_len == '0) ? sync2 : deb;

    // Synchronise, then only follow the line once it has differed long enough.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            deb   <= 1'b0;
            cnt   <= '0;
        end else begin
            sync1 <= din;
            sync2 <= sync1;
            if (filt_len == '0) begin
                deb <= sync2;
                cnt <= '0;
            end else if (sync2 == deb) begin
                cnt <= '0;
            end else if (cnt >= filt_len - FILT_W'(1)) begin
                deb <= sync2;
                cnt <= '0;
            end else begin
                cnt <= cnt + FILT_W'(1);
            end
        end
    end

endmodule

// File: rtl/grab_trigger_ctrl.sv
// Multi-source grab trigger controller with delay, overlap slot and miss counter.
module grab_trigger_ctrl
    import grab_trigger_ctrl_pkg::*;
#(
    parameter int unsigned NUM_HW_TRIG = DEF_NUM_HW_TRIG,
    parameter int unsigned FILT_W      = DEF_FILT_W,
    parameter int unsigned DLY_W       = DEF_DLY_W,
    parameter int unsigned CNT_W       = DEF_CNT_W
) (
    input  logic                           sys_clk,
    input  logic                           sys_reset_n,
    input  logic                           cfg_grab_en,
    input  logic [SRC_W-1:0]               cfg_trig_src,
    input  logic [ACT_W-1:0]               cfg_trig_act,
    input  logic [$clog2(NUM_HW_TRIG)-1:0] cfg_hw_sel,
    input  logic [FILT_W-1:0]              cfg_filt_len,
    input  logic [DLY_W-1:0]               cfg_trig_dly,
    input  logic                           cfg_overlap_en,
    input  logic [NUM_HW_TRIG-1:0]         hw_trig_in,
    input  logic                           sw_trig,
    input  logic                           sfnc_trig,
    output logic                           grab_req,
    input  logic                           grab_ack,
    output logic                           trig_rdy,
    output logic                           trig_pending,
    output logic [CNT_W-1:0]               missed_cnt,
    input  logic                           missed_clr
);

    localparam int unsigned SEL_W = $clog2(NUM_HW_TRIG);

    grab_state_t       state;
    trig_cfg_t         lat_cfg;
    logic [SEL_W-1:0]  lat_sel;
    logic [DLY_W-1:0]  lat_dly;
    logic [DLY_W-1:0]  dly_cnt;
    logic [NUM_HW_TRIG-1:0] deb_c;
    logic [NUM_HW_TRIG-1:0] line_prev;
    logic              trig_evt;
    logic              trig_cnt;
    logic              idle_c;
    trig_cfg_t         eff_cfg_c;
    logic [SEL_W-1:0]  eff_sel_c;
    logic              line_cur_c;
    logic              line_old_c;
    logic              hw_hit_c;
    logic              evt_c;
    logic              countable_c;
    logic              slot_free_c;
    logic              take_c;
    logic              miss_c;

    // One synchroniser/debouncer per hardware line.
    for (genvar i = 0; i < NUM_HW_TRIG; i++) begin : g_line
        grab_trig_filter #(.FILT_W(FILT_W)) u_filt (
            .clk      (sys_clk),
            .rst_n    (sys_reset_n),
            .din      (hw_trig_in[i]),
            .filt_len (cfg_filt_len),
            .deb_c    (deb_c[i])
        );
    end

    assign idle_c = (state == ST_IDLE);

    // Decode the active source: live config in IDLE, captured config while busy.
    always_comb begin
        eff_cfg_c   = lat_cfg;
        eff_sel_c   = lat_sel;
        hw_hit_c    = 1'b0;
        evt_c       = 1'b0;
        countable_c = 1'b0;
        if (idle_c) begin
            eff_cfg_c.src = cfg_trig_src;
            eff_cfg_c.act = cfg_trig_act;
            eff_sel_c     = cfg_hw_sel;
        end
        line_cur_c = deb_c[eff_sel_c];
        line_old_c = line_prev[eff_sel_c];
        case (eff_cfg_c.act)
            ACT_FALLING:  hw_hit_c = ~line_cur_c & line_old_c;
            ACT_ANY:      hw_hit_c = line_cur_c ^ line_old_c;
            ACT_LEVEL_HI: hw_hit_c = line_cur_c & idle_c;
            ACT_LEVEL_LO: hw_hit_c = ~line_cur_c & idle_c;
            default:      hw_hit_c = line_cur_c & ~line_old_c;
        endcase
        case (eff_cfg_c.src)
            SRC_IMMEDIATE: evt_c = idle_c;
            SRC_HW_TRIG: begin
                evt_c       = hw_hit_c;
                countable_c = is_edge_act(eff_cfg_c.act);
            end
            SRC_SW_TRIG: begin
                evt_c       = sw_trig;
                countable_c = 1'b1;
            end
            SRC_SFNC: begin
                evt_c       = sfnc_trig;
                countable_c = 1'b1;
            end
            default: evt_c = 1'b0;
        endcase
    end

    // Registered event pulse plus a flag telling whether it may be queued or missed.
    always_ff @(posedge sys_clk or negedge sys_reset_n) begin
        if (!sys_reset_n) begin
            trig_evt  <= 1'b0;
            trig_cnt  <= 1'b0;
            line_prev <= '0;
        end else begin
            trig_evt  <= cfg_grab_en & evt_c;
            trig_cnt  <= cfg_grab_en & evt_c & countable_c;
            line_prev <= deb_c;
        end
    end

    // IDLE -> DELAY -> REQ sequencing with registered request/ready outputs.
    always_ff @(posedge sys_clk or negedge sys_reset_n) begin
        if (!sys_reset_n) begin
            state    <= ST_IDLE;
            grab_req <= 1'b0;
            trig_rdy <= 1'b0;
            dly_cnt  <= '0;
            lat_cfg  <= '0;
            lat_sel  <= '0;
            lat_dly  <= '0;
        end else begin
            trig_rdy <= 1'b0;
            case (state)
                ST_IDLE: begin
                    trig_rdy <= cfg_grab_en;
                    if (cfg_grab_en && (trig_evt || trig_pending)) begin
                        lat_cfg.src <= cfg_trig_src;
                        lat_cfg.act <= cfg_trig_act;
                        lat_sel     <= cfg_hw_sel;
                        lat_dly     <= cfg_trig_dly;
                        trig_rdy    <= 1'b0;
                        if (cfg_trig_dly != '0) begin
                            state   <= ST_DELAY;
                            dly_cnt <= cfg_trig_dly;
                        end else begin
                            state    <= ST_REQ;
                            grab_req <= 1'b1;
                        end
                    end
                end
                ST_DELAY: begin
                    if (!cfg_grab_en) begin
                        state <= ST_IDLE;
                    end else if (dly_cnt == DLY_W'(1)) begin
                        state    <= ST_REQ;
                        grab_req <= 1'b1;
                    end else begin
                        dly_cnt <= dly_cnt - DLY_W'(1);
                    end
                end
                ST_REQ: begin
                    if (grab_ack) begin
                        grab_req <= 1'b0;
                        if (trig_pending && cfg_grab_en) begin
                            if (lat_dly != '0) begin
                                state   <= ST_DELAY;
                                dly_cnt <= lat_dly;
                            end else begin
                                grab_req <= 1'b1;
                            end
                        end else begin
                            state    <= ST_IDLE;
                            trig_rdy <= cfg_grab_en;
                        end
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    grab_req <= 1'b0;
                end
            endcase
        end
    end

    // A countable trigger while busy either fills the free slot or is a miss.
    assign slot_free_c = cfg_overlap_en & ~trig_pending;
    assign take_c      = trig_cnt & ~idle_c & slot_free_c;
    assign miss_c      = trig_cnt & ~idle_c & ~slot_free_c;

    // Overlap slot: filled while busy, consumed on relaunch, dropped when disabled.
    always_ff @(posedge sys_clk or negedge sys_reset_n) begin
        if (!sys_reset_n) begin
            trig_pending <= 1'b0;
        end else if (!cfg_grab_en) begin
            trig_pending <= 1'b0;
        end else if (take_c) begin
            trig_pending <= 1'b1;
        end else if (idle_c || ((state == ST_REQ) && grab_ack)) begin
            trig_pending <= 1'b0;
        end
    end

    // Saturating miss counter; a clear overrides a simultaneous increment.
    always_ff @(posedge sys_clk or negedge sys_reset_n) begin
        if (!sys_reset_n) begin
            missed_cnt <= '0;
        end else if (missed_clr) begin
            missed_cnt <= '0;
        end else if (miss_c && (missed_cnt != {CNT_W{1'b1}})) begin
            missed_cnt <= missed_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_grab_trigger_ctrl.sv
// Directed bench for grab_trigger_ctrl with a narrow miss counter.
module tb_grab_trigger_ctrl;

    localparam int unsigned NUM_HW = 4;
    localparam int unsigned FW     = 8;
    localparam int unsigned DW     = 24;
    localparam int unsigned CW     = 4;

    logic              sys_clk;
    logic              sys_reset_n;
    logic              cfg_grab_en;
    logic [2:0]        cfg_trig_src;
    logic [2:0]        cfg_trig_act;
    logic [1:0]        cfg_hw_sel;
    logic [FW-1:0]     cfg_filt_len;
    logic [DW-1:0]     cfg_trig_dly;
    logic              cfg_overlap_en;
    logic [NUM_HW-1:0] hw_trig_in;
    logic              sw_trig;
    logic              sfnc_trig;
    logic              grab_req;
    logic              grab_ack;
    logic              trig_rdy;
    logic              trig_pending;
    logic [CW-1:0]     missed_cnt;
    logic              missed_clr;

    int n_pass;
    int n_total;

    grab_trigger_ctrl #(
        .NUM_HW_TRIG (NUM_HW),
        .FILT_W      (FW),
        .DLY_W       (DW),
        .CNT_W       (CW)
    ) dut (
        .sys_clk        (sys_clk),
        .sys_reset_n    (sys_reset_n),
        .cfg_grab_en    (cfg_grab_en),
        .cfg_trig_src   (cfg_trig_src),
        .cfg_trig_act   (cfg_trig_act),
        .cfg_hw_sel     (cfg_hw_sel),
        .cfg_filt_len   (cfg_filt_len),
        .cfg_trig_dly   (cfg_trig_dly),
        .cfg_overlap_en (cfg_overlap_en),
        .hw_trig_in     (hw_trig_in),
        .sw_trig        (sw_trig),
        .sfnc_trig      (sfnc_trig),
        .grab_req       (grab_req),
        .grab_ack       (grab_ack),
        .trig_rdy       (trig_rdy),
        .trig_pending   (trig_pending),
        .missed_cnt     (missed_cnt),
        .missed_clr     (missed_clr)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    // Advance n cycles; drive and sample 1 time unit after the rising edge.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge sys_clk);
            #1;
        end
    endtask

    task automatic sw_pulse();
        sw_trig = 1'b1;
        tick(1);
        sw_trig = 1'b0;
    endtask

    task automatic test_reset();
        #3;
        n_total++; if (grab_req !== 1'b0) $display("FAIL reset_grab_req got %b want 0", grab_req); else n_pass++;
        n_total++; if (trig_rdy !== 1'b0) $display("FAIL reset_trig_rdy got %b want 0", trig_rdy); else n_pass++;
        n_total++; if (trig_pending !== 1'b0) $display("FAIL reset_pending got %b want 0", trig_pending); else n_pass++;
        n_total++; if (missed_cnt !== 4'd0) $display("FAIL reset_missed got %0d want 0", missed_cnt); else n_pass++;
        tick(2);
        sys_reset_n = 1'b1;
        tick(3);
        n_total++; if (trig_rdy !== 1'b0) $display("FAIL rdy_disabled got %b want 0", trig_rdy); else n_pass++;
    endtask

    task automatic test_hw_latency();
        cfg_trig_src   = 3'd2;
        cfg_trig_act   = 3'd0;
        cfg_hw_sel     = 2'd2;
        cfg_filt_len   = '0;
        cfg_trig_dly   = '0;
        cfg_overlap_en = 1'b0;
        grab_ack       = 1'b1;
        cfg_grab_en    = 1'b1;
        tick(5);
        n_total++; if (trig_rdy !== 1'b1) $display("FAIL hw_rdy_idle got %b want 1", trig_rdy); else n_pass++;
        hw_trig_in = 4'b0100;
        tick(3);
        n_total++; if (grab_req !== 1'b0) $display("FAIL hw_req_t3 got %b want 0", grab_req); else n_pass++;
        tick(1);
        n_total++; if (grab_req !== 1'b1) $display("FAIL hw_req_t4 got %b want 1", grab_req); else n_pass++;
        n_total++; if (trig_rdy !== 1'b0) $display("FAIL hw_rdy_t4 got %b want 0", trig_rdy); else n_pass++;
        tick(1);
        n_total++; if (grab_req !== 1'b0) $display("FAIL hw_req_t5 got %b want 0", grab_req); else n_pass++;
        hw_trig_in = 4'b0000;
        tick(8);
        n_total++; if (grab_req !== 1'b0) $display("FAIL hw_fall_no_req got %b want 0", grab_req); else n_pass++;
    endtask

    task automatic test_debounce();
        logic seen;
        cfg_filt_len = 8'd5;
        tick(3);
        hw_trig_in = 4'b0100;
        tick(3);
        hw_trig_in = 4'b0000;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (grab_req === 1'b1) seen = 1'b1;
        end
        n_total++; if (seen !== 1'b0) $display("FAIL glitch_req got %b want 0", seen); else n_pass++;
        hw_trig_in = 4'b0100;
        tick(8);
        n_total++; if (grab_req !== 1'b0) $display("FAIL deb_req_t8 got %b want 0", grab_req); else n_pass++;
        tick(1);
        n_total++; if (grab_req !== 1'b1) $display("FAIL deb_req_t9 got %b want 1", grab_req); else n_pass++;
        tick(1);
        hw_trig_in = 4'b0000;
        tick(20);
        n_total++; if (missed_cnt !== 4'd0) $display("FAIL deb_missed got %0d want 0", missed_cnt); else n_pass++;
    endtask

    task automatic test_overlap();
        cfg_filt_len   = '0;
        cfg_trig_src   = 3'd3;
        cfg_trig_dly   = 24'd100;
        cfg_overlap_en = 1'b1;
        grab_ack       = 1'b0;
        tick(2);
        sw_pulse();                       // t, now t+1
        tick(9);                          // t+10
        sw_pulse();                       // t+11
        tick(2);                          // t+13
        n_total++; if (trig_pending !== 1'b1) $display("FAIL ovl_pending got %b want 1", trig_pending); else n_pass++;
        n_total++; if (missed_cnt !== 4'd0) $display("FAIL ovl_missed0 got %0d want 0", missed_cnt); else n_pass++;
        tick(7);                          // t+20
        sw_pulse();                       // t+21
        tick(4);                          // t+25
        n_total++; if (missed_cnt !== 4'd1) $display("FAIL ovl_missed1 got %0d want 1", missed_cnt); else n_pass++;
        tick(76);                         // t+101
        n_total++; if (grab_req !== 1'b0) $display("FAIL ovl_req_t101 got %b want 0", grab_req); else n_pass++;
        tick(1);                          // t+102
        n_total++; if (grab_req !== 1'b1) $display("FAIL ovl_req_t102 got %b want 1", grab_req); else n_pass++;
        tick(20);                         // t+122 = a
        n_total++; if (grab_req !== 1'b1) $display("FAIL ovl_req_held got %b want 1", grab_req); else n_pass++;
        grab_ack = 1'b1;
        tick(1);                          // a+1
        grab_ack = 1'b0;
        n_total++; if (grab_req !== 1'b0) $display("FAIL ovl_req_after_ack got %b want 0", grab_req); else n_pass++;
        n_total++; if (trig_pending !== 1'b0) $display("FAIL ovl_pending_used got %b want 0", trig_pending); else n_pass++;
        tick(99);                         // a+100
        n_total++; if (grab_req !== 1'b0) $display("FAIL ovl_req2_early got %b want 0", grab_req); else n_pass++;
        tick(1);                          // a+101
        n_total++; if (grab_req !== 1'b1) $display("FAIL ovl_req2 got %b want 1", grab_req); else n_pass++;
        grab_ack = 1'b1;
        tick(1);
        grab_ack = 1'b0;
        tick(2);
        n_total++; if (trig_rdy !== 1'b1) $display("FAIL ovl_rdy_back got %b want 1", trig_rdy); else n_pass++;
        n_total++; if (missed_cnt !== 4'd1) $display("FAIL ovl_missed_end got %0d want 1", missed_cnt); else n_pass++;
    endtask

    task automatic test_saturate();
        missed_clr = 1'b1;
        tick(1);
        missed_clr = 1'b0;
        n_total++; if (missed_cnt !== 4'd0) $display("FAIL clr_plain got %0d want 0", missed_cnt); else n_pass++;
        cfg_overlap_en = 1'b0;
        cfg_trig_dly   = '0;
        sw_pulse();
        tick(2);
        n_total++; if (grab_req !== 1'b1) $display("FAIL sat_in_req got %b want 1", grab_req); else n_pass++;
        for (int i = 0; i < 5; i++) begin
            sw_pulse();
            tick(1);
        end
        n_total++; if (missed_cnt !== 4'd5) $display("FAIL sat_count5 got %0d want 5", missed_cnt); else n_pass++;
        for (int i = 0; i < 15; i++) begin
            sw_pulse();
            tick(1);
        end
        tick(2);
        n_total++; if (missed_cnt !== 4'd15) $display("FAIL sat_count15 got %0d want 15", missed_cnt); else n_pass++;
        sw_pulse();
        missed_clr = 1'b1;
        tick(1);
        missed_clr = 1'b0;
        n_total++; if (missed_cnt !== 4'd0) $display("FAIL clr_vs_inc_sat got %0d want 0", missed_cnt); else n_pass++;
        sw_pulse();
        missed_clr = 1'b1;
        tick(1);
        missed_clr = 1'b0;
        n_total++; if (missed_cnt !== 4'd0) $display("FAIL clr_vs_inc_zero got %0d want 0", missed_cnt); else n_pass++;
        grab_ack = 1'b1;
        tick(1);
        grab_ack = 1'b0;
        tick(3);
    endtask

    task automatic test_abort();
        logic seen;
        cfg_trig_dly   = 24'd50;
        cfg_overlap_en = 1'b1;
        sw_pulse();                       // t, now t+1
        tick(4);                          // t+5
        sw_pulse();                       // t+6
        tick(4);                          // t+10
        n_total++; if (trig_pending !== 1'b1) $display("FAIL abort_pending_set got %b want 0b1", trig_pending); else n_pass++;
        cfg_grab_en = 1'b0;
        tick(1);
        n_total++; if (trig_pending !== 1'b0) $display("FAIL abort_pending_drop got %b want 0", trig_pending); else n_pass++;
        seen = 1'b0;
        for (int i = 0; i < 70; i++) begin
            tick(1);
            if (grab_req === 1'b1) seen = 1'b1;
        end
        n_total++; if (seen !== 1'b0) $display("FAIL abort_req got %b want 0", seen); else n_pass++;
        n_total++; if (missed_cnt !== 4'd0) $display("FAIL abort_missed got %0d want 0", missed_cnt); else n_pass++;
        cfg_grab_en = 1'b1;
        tick(2);
        n_total++; if (trig_rdy !== 1'b1) $display("FAIL abort_idle_rdy got %b want 1", trig_rdy); else n_pass++;
    endtask

    task automatic test_reset_midreq();
        cfg_trig_dly = '0;
        sw_pulse();
        tick(2);
        n_total++; if (grab_req !== 1'b1) $display("FAIL rst_pre_req got %b want 1", grab_req); else n_pass++;
        #2;
        sys_reset_n = 1'b0;
        #1;
        n_total++; if (grab_req !== 1'b0) $display("FAIL rst_async_req got %b want 0", grab_req); else n_pass++;
        cfg_grab_en  = 1'b0;
        cfg_trig_src = 3'd1;
        tick(2);
        sys_reset_n = 1'b1;
        tick(3);
        n_total++; if (grab_req !== 1'b0) $display("FAIL imm_disabled got %b want 0", grab_req); else n_pass++;
        cfg_grab_en = 1'b1;
        tick(1);
        n_total++; if (grab_req !== 1'b0) $display("FAIL imm_e1 got %b want 0", grab_req); else n_pass++;
        tick(1);
        n_total++; if (grab_req !== 1'b1) $display("FAIL imm_e2 got %b want 1", grab_req); else n_pass++;
        tick(5);
        n_total++; if (missed_cnt !== 4'd0) $display("FAIL imm_no_miss got %0d want 0", missed_cnt); else n_pass++;
        n_total++; if (grab_req !== 1'b1) $display("FAIL imm_req_hold got %b want 1", grab_req); else n_pass++;
        grab_ack = 1'b1;
        tick(1);
        grab_ack    = 1'b0;
        cfg_grab_en = 1'b0;
        tick(3);
    endtask

    initial begin
        n_pass         = 0;
        n_total        = 0;
        sys_reset_n    = 1'b0;
        cfg_grab_en    = 1'b0;
        cfg_trig_src   = 3'd0;
        cfg_trig_act   = 3'd0;
        cfg_hw_sel     = 2'd0;
        cfg_filt_len   = '0;
        cfg_trig_dly   = '0;
        cfg_overlap_en = 1'b0;
        hw_trig_in     = '0;
        sw_trig        = 1'b0;
        sfnc_trig      = 1'b0;
        grab_ack       = 1'b0;
        missed_clr     = 1'b0;
        test_reset();
        test_hw_latency();
        test_debounce();
        test_overlap();
        test_saturate();
        test_abort();
        test_reset_midreq();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
